// File: rtl/multicycle_computer_controller_cond_unit_pkg.sv
// Shared constants for the conditional-execution unit: condition codes,
// flag bit positions inside {N,Z,C,V}, and flag_w write-enable bit positions.
package multicycle_computer_controller_cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  // Partial flag update: flag_w[1] replaces N,Z and flag_w[0] replaces C,V.
  function automatic logic [3:0] merge_flags(input logic [3:0] old_flags,
                                             input logic [3:0] alu_flags,
                                             input logic [1:0] flag_w);
    logic [3:0] res;
    res = old_flags;
    if (flag_w[FW_NZ]) begin
      res[FLAG_N] = alu_flags[FLAG_N];
      res[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (flag_w[FW_CV]) begin
      res[FLAG_C] = alu_flags[FLAG_C];
      res[FLAG_V] = alu_flags[FLAG_V];
    end
    return res;
  endfunction

endpackage

// File: rtl/multicycle_computer_controller_cond_unit_if.sv
// Controller-side bundle of the conditional-execution unit. The master is the
// FSM/decoder/datapath side; the slave is the unit itself.
interface multicycle_computer_controller_cond_unit_if #(
  parameter int CTX_W = 1
);
  logic [3:0]       instr_cond;
  logic [3:0]       alu_flags;
  logic             cond_eval;
  logic [1:0]       flag_w;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic [CTX_W-1:0] ctx_sel;
  logic [3:0]       flags_out;
  logic             cond_ex;
  logic             pcs_g;
  logic             reg_w_g;
  logic             mem_w_g;
  logic             illegal_cond;

  modport master (
    output instr_cond, alu_flags, cond_eval, flag_w, pcs, reg_w, mem_w,
           no_write, ctx_sel,
    input  flags_out, cond_ex, pcs_g, reg_w_g, mem_w_g, illegal_cond
  );

  modport slave (
    input  instr_cond, alu_flags, cond_eval, flag_w, pcs, reg_w, mem_w,
           no_write, ctx_sel,
    output flags_out, cond_ex, pcs_g, reg_w_g, mem_w_g, illegal_cond
  );
endinterface

// File: rtl/multicycle_computer_cond_decode.sv
// Pure combinational condition-code evaluator: 4-bit cond field against
// {N,Z,C,V} gives the execute/skip decision.
module multicycle_computer_cond_decode
  import multicycle_computer_controller_cond_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_result
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_result = 1'b0;
    case (i_cond)
      COND_EQ: o_result = w_z;
      COND_NE: o_result = ~w_z;
      COND_CS: o_result = w_c;
      COND_CC: o_result = ~w_c;
      COND_MI: o_result = w_n;
      COND_PL: o_result = ~w_n;
      COND_VS: o_result = w_v;
      COND_VC: o_result = ~w_v;
      COND_HI: o_result = w_c & ~w_z;
      COND_LS: o_result = ~w_c | w_z;
      COND_GE: o_result = (w_n == w_v);
      COND_LT: o_result = (w_n != w_v);
      COND_GT: o_result = ~w_z & (w_n == w_v);
      COND_LE: o_result = w_z | (w_n != w_v);
      COND_AL: o_result = 1'b1;
      COND_NV: o_result = 1'b0;
      default: o_result = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_computer_controller_cond_unit.sv
// Conditional-execution unit: banked NZCV registers, latched CondEx, NV trap
// pulse and gating of the PC/register/memory write strobes.
module multicycle_computer_controller_cond_unit
  import multicycle_computer_controller_cond_unit_pkg::*;
#(
  parameter int N_CTX   = 2,
  parameter int CTX_W   = 1,
  parameter int NV_TRAP = 1
) (
  input logic clk,
  input logic reset,
  multicycle_computer_controller_cond_unit_if.slave bus
);

  if (N_CTX < 1) begin : g_bad_nctx
    $error("N_CTX must be at least 1");
  end
  if (CTX_W < 1 || CTX_W < $clog2(N_CTX)) begin : g_bad_ctxw
    $error("CTX_W too narrow for N_CTX");
  end

  logic [N_CTX-1:0][3:0] w_bank;
  logic [3:0]            w_flags;
  logic                  w_dec;
  logic                  w_trap;
  logic                  r_cond_ex;
  logic                  r_illegal;

  // Out-of-range contexts match no bank, so they read as all-zero flags.
  always_comb begin
    w_flags = 4'b0000;
    for (int i = 0; i < N_CTX; i++) begin
      if (32'(bus.ctx_sel) == i) begin
        w_flags = w_bank[i];
      end
    end
  end

  multicycle_computer_cond_decode u_decode (
    .i_cond   (bus.instr_cond),
    .i_flags  (w_flags),
    .o_result (w_dec)
  );

  // Each bank updates only when selected; the qualifier is the pre-edge
  // cond_ex, so a same-cycle re-evaluation cannot affect this write.
  for (genvar gi = 0; gi < N_CTX; gi++) begin : g_bank
    logic [3:0] r_bank;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_bank <= 4'b0000;
      end else if (r_cond_ex && (32'(bus.ctx_sel) == gi)) begin
        r_bank <= merge_flags(r_bank, bus.alu_flags, bus.flag_w);
      end
    end

    assign w_bank[gi] = r_bank;
  end

  assign w_trap = bus.cond_eval && (bus.instr_cond == COND_NV) && (NV_TRAP != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cond_ex <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (bus.cond_eval) begin
        r_cond_ex <= w_dec;
      end
      r_illegal <= w_trap;
    end
  end

  assign bus.flags_out    = w_flags;
  assign bus.cond_ex      = r_cond_ex;
  assign bus.illegal_cond = r_illegal;
  assign bus.pcs_g        = bus.pcs & r_cond_ex;
  assign bus.reg_w_g      = bus.reg_w & r_cond_ex & ~bus.no_write;
  assign bus.mem_w_g      = bus.mem_w & r_cond_ex;

endmodule
